// File: rtl/axis_row_generator_pkg.sv
// Shared definitions for the row-data stream generator and any future checker.
package axis_row_generator_pkg;

  // Packet type codes carried in TDATA[511:504]
  localparam logic [7:0] PKT_AXI_REQ = 8'h01;
  localparam logic [7:0] PKT_HEADER  = 8'h02;
  localparam logic [7:0] PKT_TRAILER = 8'h03;

  localparam int PKT_TYPE_MSB = 511;
  localparam int PKT_TYPE_LSB = 504;

  // Field offsets inside an AXI request word
  localparam int REQ_ADDR_LSB = 0;
  localparam int REQ_DATA_LSB = 32;
  localparam int REQ_MODE_BIT = 64;
  localparam int REQ_BITS     = REQ_MODE_BIT + 1;

  // Per-word XOR masks applied to the running pattern value, indexed by word mod 4
  localparam logic [3:0][31:0] PAT_MASKS = {32'h5555_5555, 32'hAAAA_AAAA,
                                            32'hFFFF_FFFF, 32'h0000_0000};

  // Word and bit that a requested corruption flips
  localparam int CORRUPT_WORD = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOUNDARY,
    ST_DATA,
    ST_TRAILER,
    ST_GAP
  } state_t;

endpackage

// File: rtl/axis_row_generator_row_pattern_gen.sv
// Maps a 32-bit pattern value to the 512-bit data beat the row consumer expects.
module axis_row_generator_row_pattern_gen
  import axis_row_generator_pkg::*;
#(
  parameter int DATA_WIDTH = 512
) (
  input  logic [31:0]           value,
  input  logic                  corrupt,
  output logic [DATA_WIDTH-1:0] beat
);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH / 32; gi++) begin : g_word
      if (gi == CORRUPT_WORD) begin : g_flip
        // The corruptible word gets its LSB flipped on request
        assign beat[gi*32 +: 32] = value ^ PAT_MASKS[gi % 4] ^ {31'd0, corrupt};
      end else begin : g_plain
        assign beat[gi*32 +: 32] = value ^ PAT_MASKS[gi % 4];
      end
    end
  endgenerate

endmodule

// File: rtl/axis_row_generator.sv
// Row-data stream source: header / data / trailer rows with AXI request packets
// slipped in between rows. The FSM decides which beat to load into the output
// register, so under TREADY=1 a new beat is loaded on every cycle.
module axis_row_generator
  import axis_row_generator_pkg::*;
#(
  parameter int DATA_WIDTH  = 512,
  parameter int DATA_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [63:0]           row_count,
  input  logic [15:0]           row_gap,
  input  logic [31:0]           seed,
  input  logic                  inject_error,
  output logic                  idle,
  output logic [63:0]           rows_sent,
  input  logic [71:0]           AXI_REQ_IN_TDATA,
  input  logic                  AXI_REQ_IN_TVALID,
  output logic                  AXI_REQ_IN_TREADY,
  output logic [DATA_WIDTH-1:0] AXIS_OUT_TDATA,
  output logic                  AXIS_OUT_TVALID,
  input  logic                  AXIS_OUT_TREADY,
  output logic                  AXIS_OUT_TLAST
);

  localparam int CNT_W = $clog2(DATA_CYCLES) + 1;

  state_t                  state_reg, state_next;
  logic                    out_valid_reg, out_last_reg;
  logic [DATA_WIDTH-1:0]   out_data_reg;
  logic [63:0]             rows_sent_reg, rows_loaded_reg, row_count_reg;
  logic [15:0]             row_gap_reg, gap_cnt_reg, gap_cnt_next;
  logic [CNT_W-1:0]        data_cnt_reg, data_cnt_next;
  logic [31:0]             pattern_reg;
  logic                    err_reg, abort_reg;

  logic                    can_load, req_ready, req_fire, start_fire, done;
  logic                    trailer_accept;
  logic                    load_en, load_last, pat_step, row_step;
  logic [DATA_WIDTH-1:0]   load_data, req_beat, hdr_beat, trl_beat, pat_beat;
  logic                    unused_req_bits;

  // Bits above the mode flag carry nothing
  assign unused_req_bits = ^AXI_REQ_IN_TDATA[71:REQ_BITS];

  assign can_load   = !out_valid_reg || AXIS_OUT_TREADY;
  assign req_ready  = resetn && can_load &&
                      (state_reg == ST_IDLE || state_reg == ST_BOUNDARY || state_reg == ST_GAP);
  assign req_fire   = AXI_REQ_IN_TVALID && req_ready;
  assign start_fire = start && (state_reg == ST_IDLE);
  assign done       = abort_reg || ((row_count_reg != 64'd0) && (rows_loaded_reg == row_count_reg));
  assign trailer_accept = out_valid_reg && AXIS_OUT_TREADY && out_last_reg &&
                          (out_data_reg[PKT_TYPE_MSB:PKT_TYPE_LSB] == PKT_TRAILER);

  axis_row_generator_row_pattern_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pattern (
    .value   (pattern_reg),
    .corrupt (err_reg),
    .beat    (pat_beat)
  );

  // Assemble the non-data beat formats from the current row index / request word
  always_comb begin
    req_beat = '0;
    req_beat[PKT_TYPE_MSB:PKT_TYPE_LSB] = PKT_AXI_REQ;
    req_beat[REQ_BITS-1:0] = AXI_REQ_IN_TDATA[REQ_BITS-1:0];
    hdr_beat = '0;
    hdr_beat[PKT_TYPE_MSB:PKT_TYPE_LSB] = PKT_HEADER;
    hdr_beat[63:0] = rows_loaded_reg;
    trl_beat = '0;
    trl_beat[PKT_TYPE_MSB:PKT_TYPE_LSB] = PKT_TRAILER;
    trl_beat[63:0] = rows_loaded_reg;
    trl_beat[95:64] = 32'(DATA_CYCLES);
  end

  // Next-state logic and choice of the beat to load into the output register
  always_comb begin
    state_next    = state_reg;
    load_en       = 1'b0;
    load_last     = 1'b0;
    load_data     = '0;
    pat_step      = 1'b0;
    row_step      = 1'b0;
    data_cnt_next = data_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_fire) begin
          load_en   = 1'b1;
          load_data = req_beat;
          load_last = 1'b1;
        end
        if (start) state_next = ST_BOUNDARY;
      end
      ST_BOUNDARY: begin
        if (req_fire) begin
          load_en   = 1'b1;
          load_data = req_beat;
          load_last = 1'b1;
        end else if (done) begin
          // Leave only once the last trailer is out, so rows_sent is final at idle
          if (can_load) state_next = ST_IDLE;
        end else if (can_load) begin
          load_en       = 1'b1;
          load_data     = hdr_beat;
          data_cnt_next = '0;
          state_next    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (can_load) begin
          load_en       = 1'b1;
          load_data     = pat_beat;
          pat_step      = 1'b1;
          data_cnt_next = data_cnt_reg + 1'b1;
          if (data_cnt_reg == CNT_W'(DATA_CYCLES - 1)) state_next = ST_TRAILER;
        end
      end
      ST_TRAILER: begin
        if (can_load) begin
          load_en      = 1'b1;
          load_data    = trl_beat;
          load_last    = 1'b1;
          row_step     = 1'b1;
          gap_cnt_next = row_gap_reg;
          state_next   = (row_gap_reg == 16'd0) ? ST_BOUNDARY : ST_GAP;
        end
      end
      ST_GAP: begin
        if (req_fire) begin
          load_en   = 1'b1;
          load_data = req_beat;
          load_last = 1'b1;
        end
        gap_cnt_next = gap_cnt_reg - 1'b1;
        if (gap_cnt_reg <= 16'd1) state_next = ST_BOUNDARY;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, output register, counters and latched dataset settings
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg       <= ST_IDLE;
      out_valid_reg   <= 1'b0;
      out_last_reg    <= 1'b0;
      out_data_reg    <= '0;
      rows_sent_reg   <= '0;
      rows_loaded_reg <= '0;
      row_count_reg   <= '0;
      row_gap_reg     <= '0;
      gap_cnt_reg     <= '0;
      data_cnt_reg    <= '0;
      pattern_reg     <= '0;
      err_reg         <= 1'b0;
      abort_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      data_cnt_reg <= data_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;

      if (load_en) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= load_data;
        out_last_reg  <= load_last;
      end else if (AXIS_OUT_TREADY) begin
        out_valid_reg <= 1'b0;
      end

      if (start_fire) begin
        row_count_reg <= row_count;
        row_gap_reg   <= row_gap;
      end

      if (start_fire)    pattern_reg <= seed;
      else if (pat_step) pattern_reg <= pattern_reg + 32'd1;

      // A pulse coinciding with a data load is kept for the following beat
      if (pat_step)          err_reg <= inject_error;
      else if (inject_error) err_reg <= 1'b1;

      if (start_fire)          rows_sent_reg <= '0;
      else if (trailer_accept) rows_sent_reg <= rows_sent_reg + 64'd1;

      if (start_fire)    rows_loaded_reg <= '0;
      else if (row_step) rows_loaded_reg <= rows_loaded_reg + 64'd1;

      if (state_next == ST_IDLE) abort_reg <= 1'b0;
      else if (abort)            abort_reg <= 1'b1;
    end
  end

  assign idle              = (state_reg == ST_IDLE);
  assign rows_sent         = rows_sent_reg;
  assign AXI_REQ_IN_TREADY = req_ready;
  assign AXIS_OUT_TDATA    = out_data_reg;
  assign AXIS_OUT_TVALID   = out_valid_reg;
  assign AXIS_OUT_TLAST    = out_last_reg;

endmodule

// File: tb/tb_axis_row_generator.sv
// Directed bench for axis_row_generator with an expected-beat scoreboard.
module tb_axis_row_generator;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start, abort, inject_error;
  logic [63:0]  row_count;
  logic [15:0]  row_gap;
  logic [31:0]  seed;
  logic         idle;
  logic [63:0]  rows_sent;
  logic [71:0]  AXI_REQ_IN_TDATA;
  logic         AXI_REQ_IN_TVALID;
  logic         AXI_REQ_IN_TREADY;
  logic [511:0] AXIS_OUT_TDATA;
  logic         AXIS_OUT_TVALID;
  logic         AXIS_OUT_TREADY;
  logic         AXIS_OUT_TLAST;

  axis_row_generator dut (
    .clk               (clk),
    .resetn            (resetn),
    .start             (start),
    .abort             (abort),
    .row_count         (row_count),
    .row_gap           (row_gap),
    .seed              (seed),
    .inject_error      (inject_error),
    .idle              (idle),
    .rows_sent         (rows_sent),
    .AXI_REQ_IN_TDATA  (AXI_REQ_IN_TDATA),
    .AXI_REQ_IN_TVALID (AXI_REQ_IN_TVALID),
    .AXI_REQ_IN_TREADY (AXI_REQ_IN_TREADY),
    .AXIS_OUT_TDATA    (AXIS_OUT_TDATA),
    .AXIS_OUT_TVALID   (AXIS_OUT_TVALID),
    .AXIS_OUT_TREADY   (AXIS_OUT_TREADY),
    .AXIS_OUT_TLAST    (AXIS_OUT_TLAST)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         last;
    logic         is_data;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cons_errors = 0;
  int unsigned  beats_total = 0;
  int unsigned  cyc_cnt = 0;
  logic [511:0] beat_log [256];
  int unsigned  cyc_log [256];
  logic         rand_bp = 1'b0;
  logic         prev_stall = 1'b0;
  logic [511:0] prev_data;
  logic         prev_last;
  logic         req_fire_seen;
  logic [31:0]  pat_model;
  int unsigned  base;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_data(input logic [31:0] v);
    logic [511:0] b;
    logic [31:0]  m;
    for (int k = 0; k < 16; k++) begin
      case (k % 4)
        0:       m = 32'h0000_0000;
        1:       m = 32'hFFFF_FFFF;
        2:       m = 32'hAAAA_AAAA;
        default: m = 32'h5555_5555;
      endcase
      b[k*32 +: 32] = v ^ m;
    end
    return b;
  endfunction

  task automatic push_beat(input logic [511:0] d, input logic l, input logic isd);
    exp_t e;
    e.data = d;
    e.last = l;
    e.is_data = isd;
    exp_q.push_back(e);
  endtask

  task automatic push_row(input logic [63:0] idx);
    logic [511:0] b;
    b = '0;
    b[511:504] = 8'h02;
    b[63:0] = idx;
    push_beat(b, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      push_beat(mk_data(pat_model), 1'b0, 1'b1);
      pat_model = pat_model + 32'd1;
    end
    b = '0;
    b[511:504] = 8'h03;
    b[63:0] = idx;
    b[95:64] = 32'd32;
    push_beat(b, 1'b1, 1'b0);
  endtask

  task automatic push_req(input logic [31:0] addr, input logic [31:0] data, input logic mode);
    logic [511:0] b;
    b = '0;
    b[511:504] = 8'h01;
    b[31:0] = addr;
    b[63:32] = data;
    b[64] = mode;
    push_beat(b, 1'b1, 1'b0);
  endtask

  // One clock: observe outputs on the falling edge, then return just after the rising edge
  task automatic cyc_step();
    exp_t         e;
    logic [511:0] flipped;
    @(negedge clk);
    cyc_cnt++;
    req_fire_seen = AXI_REQ_IN_TVALID && AXI_REQ_IN_TREADY;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", AXIS_OUT_TVALID, 1'b1);
        chk("stall_data", AXIS_OUT_TDATA, prev_data);
        chk("stall_last", AXIS_OUT_TLAST, prev_last);
      end
      if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed=%0h expected=none", AXIS_OUT_TDATA);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          flipped = e.data ^ (512'd1 << 32);
          checks++;
          assert ((AXIS_OUT_TDATA === e.data) || (e.is_data && AXIS_OUT_TDATA === flipped)) else begin
            errors++;
            $error("FAIL beat%0d_data observed=%0h expected=%0h", beats_total, AXIS_OUT_TDATA, e.data);
          end
          if (e.is_data && AXIS_OUT_TDATA === flipped) cons_errors++;
          chk("beat_last", AXIS_OUT_TLAST, e.last);
        end
        beat_log[beats_total & 255] = AXIS_OUT_TDATA;
        cyc_log[beats_total & 255] = cyc_cnt;
        beats_total++;
      end
      prev_stall = AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
      prev_data  = AXIS_OUT_TDATA;
      prev_last  = AXIS_OUT_TLAST;
    end
    @(posedge clk);
    #1;
    if (rand_bp) AXIS_OUT_TREADY = ($urandom_range(0, 1) == 1);
  endtask

  task automatic start_ds(input logic [63:0] cnt, input logic [15:0] gap, input logic [31:0] sd);
    row_count = cnt;
    row_gap = gap;
    seed = sd;
    chk("idle_before_start", idle, 1'b1);
    start = 1'b1;
    cyc_step();
    start = 1'b0;
    chk("idle_fall", idle, 1'b0);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    do begin
      cyc_step();
      n++;
    end while (!(idle && !AXIS_OUT_TVALID) && n < budget);
    chk(tag, (n < budget), 1'b1);
  endtask

  task automatic wait_beats(input string tag, input int unsigned target, input int budget);
    int n = 0;
    while ((beats_total - base) < target && n < budget) begin
      cyc_step();
      n++;
    end
    chk(tag, (n < budget), 1'b1);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    inject_error = 1'b0;
    row_count = '0;
    row_gap = '0;
    seed = '0;
    AXI_REQ_IN_TDATA = '0;
    AXI_REQ_IN_TVALID = 1'b0;
    AXIS_OUT_TREADY = 1'b1;
    repeat (3) cyc_step();
    chk("reset_idle", idle, 1'b1);
    chk("reset_rows_sent", rows_sent, 64'd0);
    chk("reset_tvalid", AXIS_OUT_TVALID, 1'b0);
    chk("reset_req_tready", AXI_REQ_IN_TREADY, 1'b0);
    resetn = 1'b1;
    cyc_step();

    // Two rows back-to-back, seed 0, no gap
    pat_model = 32'd0;
    push_row(64'd0);
    push_row(64'd1);
    base = beats_total;
    start_ds(64'd2, 16'd0, 32'd0);
    wait_idle("t1_idle", 300);
    chk("t1_beats", beats_total - base, 32'd68);
    chk("t1_back_to_back", cyc_log[(base + 67) & 255] - cyc_log[base & 255], 32'd67);
    chk("t1_data0_words", beat_log[(base + 1) & 255][127:0],
        128'h5555_5555_AAAA_AAAA_FFFF_FFFF_0000_0000);
    chk("t1_beat33_type", beat_log[(base + 33) & 255][511:504], 8'h03);
    chk("t1_beat33_index", beat_log[(base + 33) & 255][63:0], 64'd0);
    chk("t1_rows_sent", rows_sent, 64'd2);
    chk("t1_queue_empty", exp_q.size(), 32'd0);

    // 100 rows under random backpressure
    pat_model = 32'h1234_5678;
    for (int r = 0; r < 100; r++) push_row(64'(r));
    rand_bp = 1'b1;
    cons_errors = 0;
    start_ds(64'd100, 16'd3, 32'h1234_5678);
    wait_idle("t2_idle", 30000);
    rand_bp = 1'b0;
    AXIS_OUT_TREADY = 1'b1;
    chk("t2_rows_sent", rows_sent, 64'd100);
    chk("t2_consumer_errors", cons_errors, 32'd0);
    chk("t2_queue_empty", exp_q.size(), 32'd0);

    // Single corrupted data beat during row 1
    pat_model = 32'h100;
    for (int r = 0; r < 3; r++) push_row(64'(r));
    cons_errors = 0;
    base = beats_total;
    start_ds(64'd3, 16'd1, 32'h100);
    wait_beats("t3_reach_row1", 40, 200);
    inject_error = 1'b1;
    cyc_step();
    inject_error = 1'b0;
    wait_idle("t3_idle", 400);
    chk("t3_consumer_errors", cons_errors, 32'd1);
    chk("t3_queue_empty", exp_q.size(), 32'd0);

    // AXI request raised mid-row must come out right after the trailer
    pat_model = 32'd5;
    push_row(64'd0);
    push_req(32'h1000, 32'hDEAD, 1'b1);
    push_row(64'd1);
    base = beats_total;
    start_ds(64'd2, 16'd2, 32'd5);
    wait_beats("t4_reach_data", 5, 100);
    AXI_REQ_IN_TDATA = {7'd0, 1'b1, 32'hDEAD, 32'h1000};
    AXI_REQ_IN_TVALID = 1'b1;
    begin
      int n = 0;
      do begin
        cyc_step();
        n++;
      end while (!req_fire_seen && n < 200);
      chk("t4_req_accepted", req_fire_seen, 1'b1);
    end
    AXI_REQ_IN_TVALID = 1'b0;
    wait_idle("t4_idle", 300);
    chk("t4_queue_empty", exp_q.size(), 32'd0);

    // Endless dataset aborted mid-row finishes that row only
    pat_model = 32'd7;
    push_row(64'd0);
    base = beats_total;
    start_ds(64'd0, 16'd0, 32'd7);
    wait_beats("t5_reach_data", 10, 100);
    abort = 1'b1;
    cyc_step();
    abort = 1'b0;
    wait_idle("t5_idle", 200);
    chk("t5_rows_sent", rows_sent, 64'd1);
    chk("t5_queue_empty", exp_q.size(), 32'd0);

    // Pattern wrap from FFFF_FFFE
    pat_model = 32'hFFFF_FFFE;
    push_row(64'd0);
    base = beats_total;
    start_ds(64'd1, 16'd0, 32'hFFFF_FFFE);
    wait_idle("t6_idle", 200);
    chk("t6_wrap_word0", beat_log[(base + 3) & 255][31:0], 32'd0);
    chk("t6_wrap_word1", beat_log[(base + 3) & 255][63:32], 32'hFFFF_FFFF);
    chk("t6_queue_empty", exp_q.size(), 32'd0);

    // Reset in the middle of a row
    pat_model = 32'd0;
    push_row(64'd0);
    base = beats_total;
    start_ds(64'd1, 16'd0, 32'd0);
    wait_beats("t7_reach_data", 8, 100);
    resetn = 1'b0;
    cyc_step();
    chk("t7_tvalid_after_reset", AXIS_OUT_TVALID, 1'b0);
    chk("t7_idle_after_reset", idle, 1'b1);
    chk("t7_rows_after_reset", rows_sent, 64'd0);
    exp_q.delete();
    resetn = 1'b1;
    cyc_step();
    chk("t7_req_tready_idle", AXI_REQ_IN_TREADY, 1'b1);
    repeat (5) cyc_step();
    chk("t7_no_resume", AXIS_OUT_TVALID, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
